// File: rtl/level_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : level_pulse_generator
// Description : Converts single-cycle request ticks into fixed-width level
//               pulses separated by a guaranteed low gap, with a bounded
//               queue of pending requests and a dropped-request flag.
// Revision    : 1.0 - initial release
// ============================================================================
module level_pulse_generator #(
    parameter int HIGH_LEN    = 4,
    parameter int LOW_LEN     = 2,
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic update,
    input  logic tick,
    output logic level,
    output logic busy,
    output logic dropped
);

    localparam logic [CNT_W-1:0]  C_HIGH_RELOAD = CNT_W'(HIGH_LEN - 1);
    localparam logic [CNT_W-1:0]  C_LOW_RELOAD  = CNT_W'(LOW_LEN - 1);
    localparam logic [PEND_W-1:0] C_MAX_PEND    = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PEND_W-1:0]   r_pending;
    logic                r_level;
    logic                r_dropped;

    logic                w_have_pending;
    logic                w_launch;

    // Launch decisions look only at the registered queue, so a tick is never
    // consumed on the same edge that records it.
    assign w_have_pending = (r_pending != '0);

    always_comb begin
        w_launch = 1'b0;
        if (update) begin
            case (r_state)
                S_IDLE:  w_launch = w_have_pending;
                S_GAP:   w_launch = (r_cnt == '0) && w_have_pending;
                default: w_launch = 1'b0;
            endcase
        end
    end

    // Pending queue runs every clock, independent of the update strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= 1'b0;
            case ({tick, w_launch})
                2'b10: begin
                    if (r_pending == C_MAX_PEND) begin
                        r_dropped <= 1'b1;
                    end else begin
                        r_pending <= r_pending + 1'b1;
                    end
                end
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state <= S_PULSE;
                        r_cnt   <= C_HIGH_RELOAD;
                        r_level <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (update) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_state <= S_GAP;
                            r_cnt   <= C_LOW_RELOAD;
                            r_level <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (update) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else if (w_launch) begin
                            r_state <= S_PULSE;
                            r_cnt   <= C_HIGH_RELOAD;
                            r_level <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign level   = r_level;
    assign dropped = r_dropped;
    assign busy    = (r_state != S_IDLE) || w_have_pending;

endmodule
`default_nettype wire

// File: tb/tb_level_pulse_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_pulse_generator
// Description : Directed scoreboard bench; expected pulses and dropped flags
//               are queued by stimulus and matched by an output monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_pulse_generator;

    logic clk;
    logic reset;
    logic update;
    logic tick;
    logic level;
    logic busy;
    logic dropped;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int rise;
        int width;
    } pulse_t;

    pulse_t exp_q[$];
    int     drop_q[$];

    level_pulse_generator #(
        .HIGH_LEN    (4),
        .LOW_LEN     (2),
        .MAX_PENDING (3),
        .CNT_W       (8),
        .PEND_W      (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .update  (update),
        .tick    (tick),
        .level   (level),
        .busy    (busy),
        .dropped (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc equals N once rising edge N has occurred
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int rise, input int width);
        pulse_t p;
        p.rise  = rise;
        p.width = width;
        exp_q.push_back(p);
    endtask

    // Output monitor: measures each level pulse and each dropped flag.
    initial begin : monitor
        logic   prev_level;
        int     rise_at;
        pulse_t p;
        int     d;
        prev_level = 1'b0;
        rise_at    = 0;
        forever begin
            @(negedge clk);
            if (level && !prev_level) rise_at = cyc;
            if (!level && prev_level) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse_rise", rise_at, -1);
                end else begin
                    p = exp_q.pop_front();
                    chk("pulse_rise", rise_at, p.rise);
                    chk("pulse_width", cyc - rise_at, p.width);
                end
            end
            prev_level = level;
            if (dropped) begin
                if (drop_q.size() == 0) begin
                    chk("unexpected_dropped", cyc, -1);
                end else begin
                    d = drop_q.pop_front();
                    chk("dropped_cycle", cyc, d);
                end
            end
        end
    end

    task automatic drive(input logic t, input logic u);
        tick   = t;
        update = u;
        @(posedge clk);
        #2;
        tick = 1'b0;
    endtask

    task automatic end_of_test(input string name);
        chk({name, "_pulses_outstanding"}, exp_q.size(), 0);
        chk({name, "_drops_outstanding"}, drop_q.size(), 0);
        chk({name, "_busy_idle"}, int'(busy), 0);
        exp_q.delete();
        drop_q.delete();
    endtask

    initial begin : stim
        int b;
        reset  = 1'b1;
        tick   = 1'b0;
        update = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_level", int'(level), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_dropped", int'(dropped), 0);
        reset = 1'b0;
        repeat (2) drive(1'b0, 1'b0);

        // T1: single tick, update every clock
        b = cyc;
        push_pulse(b + 11, 4);
        for (int e = 1; e <= 30; e++) begin
            drive(e == 10, 1'b1);
            if (e == 10) chk("t1_busy_pending", int'(busy), 1);
            if (e == 12) chk("t1_level_high", int'(level), 1);
        end
        end_of_test("t1");

        // T2: three ticks back to back, gaps of exactly LOW_LEN
        b = cyc;
        push_pulse(b + 11, 4);
        push_pulse(b + 17, 4);
        push_pulse(b + 23, 4);
        for (int e = 1; e <= 36; e++) begin
            drive(e >= 10 && e <= 12, 1'b1);
            if (e >= 10 && e <= 28) chk("t2_busy_held", int'(busy), 1);
        end
        end_of_test("t2");

        // T3: five ticks while frozen, two dropped, three pulses later
        b = cyc;
        drop_q.push_back(b + 8);
        drop_q.push_back(b + 9);
        push_pulse(b + 11, 4);
        push_pulse(b + 17, 4);
        push_pulse(b + 23, 4);
        for (int e = 1; e <= 36; e++) begin
            drive(e >= 5 && e <= 9, e >= 11);
            if (e == 10) chk("t3_frozen_level", int'(level), 0);
        end
        end_of_test("t3");

        // T4: update every 4th clock stretches width and gap by 4
        b = cyc;
        push_pulse(b + 4, 16);
        push_pulse(b + 28, 16);
        for (int e = 1; e <= 60; e++) begin
            drive(e == 2 || e == 6, (e % 4) == 0);
        end
        end_of_test("t4");

        // T5: reset in the middle of the first of three queued pulses
        b = cyc;
        push_pulse(b + 3, 2);
        for (int e = 1; e <= 5; e++) begin
            drive(e >= 2 && e <= 4, 1'b1);
        end
        reset = 1'b1;
        #1;
        chk("t5_level_async_clear", int'(level), 0);
        chk("t5_busy_async_clear", int'(busy), 0);
        chk("t5_dropped_async_clear", int'(dropped), 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            drive(1'b0, 1'b1);
        end
        end_of_test("t5");

        // T6: tick on the launch edge keeps one request queued
        b = cyc;
        push_pulse(b + 2, 4);
        push_pulse(b + 8, 4);
        for (int e = 1; e <= 20; e++) begin
            drive(e == 1 || e == 2, 1'b1);
            if (e == 7) chk("t6_busy_in_gap", int'(busy), 1);
        end
        end_of_test("t6");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
